decode_issue_reg: RTL and testbench

// - Parametrised successor to the combinational decode stage: registered decode->execute boundary with valid/ready handshake.
// - Generalised N-source operand forwarding with fixed priority, plus load-use (pending-result) hazard interlock.
// - Also provides flush and a saturating hazard-stall counter. Sits between fetch/decoder and execute; the regfile is read combinationally upstream.

---
 rtl/decode_issue_reg.sv | 122 ++++++++++++
 tb/tb_decode_issue_reg.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_reg.sv
// Registered decode->execute boundary with valid/ready handshake, fixed-priority
// N-source operand forwarding, load-use interlock, flush and a saturating stall counter.
module decode_issue_reg #(
   parameter int XLEN    = 64,
   parameter int NUM_FWD = 3,
   parameter int CTL_W   = 32,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [XLEN-1:0]         in_pc,
   input  logic [31:0]             in_instr,
   input  logic [CTL_W-1:0]        in_ctl,
   input  logic [XLEN-1:0]         in_imm,
   input  logic [XLEN-1:0]         rf_rd1,
   input  logic [XLEN-1:0]         rf_rd2,
   input  logic [NUM_FWD-1:0]      fwd_valid,
   input  logic [NUM_FWD*5-1:0]    fwd_dst,
   input  logic [NUM_FWD-1:0]      fwd_pending,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_pc,
   output logic [31:0]             out_instr,
   output logic [CTL_W-1:0]        out_ctl,
   output logic [XLEN-1:0]         out_imm,
   output logic [XLEN-1:0]         out_srca,
   output logic [XLEN-1:0]         out_srcb,
   output logic [4:0]              out_rs1,
   output logic [4:0]              out_rs2,
   output logic [4:0]              out_dst,
   output logic                    hazard,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]      state;
   logic [4:0]      rs1, rs2;
   logic [XLEN-1:0] srca_res, srcb_res;
   logic            hit_a, hit_b, haz_a, haz_b;
   logic            capture;

   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];

   // Lowest-index matching source wins; a pending winner interlocks, but a
   // pending older source hidden behind a ready younger one does not.
   always_comb begin
      srca_res = rf_rd1;
      srcb_res = rf_rd2;
      hit_a    = 1'b0;
      hit_b    = 1'b0;
      haz_a    = 1'b0;
      haz_b    = 1'b0;
      for (int i = 0; i < NUM_FWD; i++) begin
         if (!hit_a && fwd_valid[i] && (fwd_dst[i*5 +: 5] == rs1)) begin
            hit_a    = 1'b1;
            srca_res = fwd_data[i*XLEN +: XLEN];
            haz_a    = fwd_pending[i];
         end
         if (!hit_b && fwd_valid[i] && (fwd_dst[i*5 +: 5] == rs2)) begin
            hit_b    = 1'b1;
            srcb_res = fwd_data[i*XLEN +: XLEN];
            haz_b    = fwd_pending[i];
         end
      end
      if (rs1 == 5'd0) begin
         srca_res = '0;
         haz_a    = 1'b0;
      end
      if (rs2 == 5'd0) begin
         srcb_res = '0;
         haz_b    = 1'b0;
      end
   end

   assign out_valid = (state == FULL);
   assign hazard    = in_valid && (haz_a || haz_b);
   assign in_ready  = !flush && !hazard && (!out_valid || out_ready);
   assign capture   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         out_pc    <= '0;
         out_instr <= '0;
         out_ctl   <= '0;
         out_imm   <= '0;
         out_srca  <= '0;
         out_srcb  <= '0;
         out_rs1   <= '0;
         out_rs2   <= '0;
         out_dst   <= '0;
         stall_cnt <= '0;
      end else begin
         if (hazard && !flush && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush) begin
            state <= EMPTY;
         end else if (capture) begin
            state     <= FULL;
            out_pc    <= in_pc;
            out_instr <= in_instr;
            out_ctl   <= in_ctl;
            out_imm   <= in_imm;
            out_srca  <= srca_res;
            out_srcb  <= srcb_res;
            out_rs1   <= rs1;
            out_rs2   <= rs2;
            out_dst   <= in_instr[11:7];
         end else if (out_ready) begin
            state <= EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_decode_issue_reg.sv
// Self-checking bench for decode_issue_reg: vector table for forwarding/capture,
// scoreboard on issued instructions, hand sequences for stall, hold, flush and reset.
module tb_decode_issue_reg;
   localparam int XLEN    = 64;
   localparam int NUM_FWD = 3;
   localparam int CTL_W   = 32;
   localparam int CNT_W   = 2;

   logic                    clk;
   logic                    reset;
   logic                    in_valid;
   logic                    in_ready;
   logic [XLEN-1:0]         in_pc;
   logic [31:0]             in_instr;
   logic [CTL_W-1:0]        in_ctl;
   logic [XLEN-1:0]         in_imm;
   logic [XLEN-1:0]         rf_rd1;
   logic [XLEN-1:0]         rf_rd2;
   logic [NUM_FWD-1:0]      fwd_valid;
   logic [NUM_FWD*5-1:0]    fwd_dst;
   logic [NUM_FWD-1:0]      fwd_pending;
   logic [NUM_FWD*XLEN-1:0] fwd_data;
   logic                    flush;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         out_pc;
   logic [31:0]             out_instr;
   logic [CTL_W-1:0]        out_ctl;
   logic [XLEN-1:0]         out_imm;
   logic [XLEN-1:0]         out_srca;
   logic [XLEN-1:0]         out_srcb;
   logic [4:0]              out_rs1;
   logic [4:0]              out_rs2;
   logic [4:0]              out_dst;
   logic                    hazard;
   logic [CNT_W-1:0]        stall_cnt;

   decode_issue_reg #(
      .XLEN(XLEN), .NUM_FWD(NUM_FWD), .CTL_W(CTL_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .in_ctl(in_ctl), .in_imm(in_imm),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_pending(fwd_pending), .fwd_data(fwd_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_ctl(out_ctl), .out_imm(out_imm),
      .out_srca(out_srca), .out_srcb(out_srcb),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_dst(out_dst),
      .hazard(hazard), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] rf1, rf2;
      logic [2:0]  fv, fp;
      logic [4:0]  fd0, fd1, fd2;
      logic [63:0] f0, f1, f2;
      logic [63:0] ea, eb;
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [63:0] srca, srcb;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[7];
   vec_t hz;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mkInstr(input vec_t v);
      return {7'b0, v.rs2, v.rs1, 3'b000, v.rd, 7'h33};
   endfunction

   task automatic applyStimulus(input vec_t v, input logic [63:0] pc, input logic expect_accept);
      exp_t e;
      in_valid    = 1'b1;
      in_pc       = pc;
      in_instr    = mkInstr(v);
      in_ctl      = pc[31:0] ^ 32'h5A5A_0000;
      in_imm      = ~pc;
      rf_rd1      = v.rf1;
      rf_rd2      = v.rf2;
      fwd_valid   = v.fv;
      fwd_pending = v.fp;
      fwd_dst     = {v.fd2, v.fd1, v.fd0};
      fwd_data    = {v.f2, v.f1, v.f0};
      if (expect_accept) begin
         e.pc    = pc;
         e.instr = mkInstr(v);
         e.srca  = v.ea;
         e.srcb  = v.eb;
         sb.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every accepted transfer on the output side must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_issue: got pc 0x%0h expected no instruction", out_pc);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("sb_pc", out_pc, mon_e.pc);
            checkOutput("sb_instr", 64'(out_instr), 64'(mon_e.instr));
            checkOutput("sb_ctl", 64'(out_ctl), 64'(mon_e.pc[31:0] ^ 32'h5A5A_0000));
            checkOutput("sb_imm", out_imm, ~mon_e.pc);
            checkOutput("sb_srca", out_srca, mon_e.srca);
            checkOutput("sb_srcb", out_srcb, mon_e.srcb);
            checkOutput("sb_rs1", 64'(out_rs1), 64'(mon_e.instr[19:15]));
            checkOutput("sb_rs2", 64'(out_rs2), 64'(mon_e.instr[24:20]));
            checkOutput("sb_dst", 64'(out_dst), 64'(mon_e.instr[11:7]));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no finish expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      //          rs1    rs2    rd    rf1          rf2          fv      fp      fd0    fd1    fd2    f0          f1            f2          ea           eb
      vecs[0] = '{5'd5,  5'd6,  5'd1, 64'h11,      64'h22,      3'b101, 3'b000, 5'd5,  5'd0,  5'd5,  64'hAA,     64'h0,        64'hCC,     64'hAA,      64'h22};
      vecs[1] = '{5'd3,  5'd0,  5'd2, 64'h33,      64'h44,      3'b001, 3'b000, 5'd0,  5'd0,  5'd0,  64'hFF,     64'h0,        64'h0,      64'h33,      64'h0};
      vecs[2] = '{5'd5,  5'd5,  5'd4, 64'h1,       64'h2,       3'b011, 3'b010, 5'd5,  5'd5,  5'd0,  64'hAA,     64'hBB,       64'h0,      64'hAA,      64'hAA};
      vecs[3] = '{5'd8,  5'd9,  5'd6, 64'h3,       64'h4,       3'b110, 3'b000, 5'd8,  5'd8,  5'd9,  64'hA0,     64'hB1,       64'hC2,     64'hB1,      64'hC2};
      vecs[4] = '{5'd10, 5'd10, 5'd7, 64'h1234,    64'h5678,    3'b000, 3'b111, 5'd10, 5'd10, 5'd10, 64'hE0,     64'hE1,       64'hE2,     64'h1234,    64'h5678};
      vecs[5] = '{5'd0,  5'd12, 5'd8, 64'h9,       64'h8,       3'b111, 3'b001, 5'd0,  5'd12, 5'd12, 64'h55,     64'hBEEF,     64'hDEAD,   64'h0,       64'hBEEF};
      vecs[6] = '{5'd31, 5'd31, 5'd9, 64'h7,       64'h6,       3'b100, 3'b000, 5'd1,  5'd2,  5'd31, 64'h0,      64'h0,        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      hz      = '{5'd7,  5'd1,  5'd3, 64'h70,      64'h1,       3'b001, 3'b001, 5'd7,  5'd0,  5'd0,  64'h77,     64'h0,        64'h0,      64'h77,      64'h1};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      in_pc = '0; in_instr = '0; in_ctl = '0; in_imm = '0; rf_rd1 = '0; rf_rd2 = '0;
      fwd_valid = '0; fwd_dst = '0; fwd_pending = '0; fwd_data = '0;
      tick();
      tick();
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'd0);
      checkOutput("reset_out_srca", out_srca, 64'd0);
      reset = 1'b0;

      // Back-to-back issue of the forwarding table, one per cycle.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i], 64'h1000 + 64'(i * 4), 1'b1);
         #1;
         checkOutput($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'd1);
         checkOutput($sformatf("tbl%0d_hazard", i), 64'(hazard), 64'd0);
         tick();
      end
      in_valid = 1'b0;
      tick();
      checkOutput("drain_out_valid", 64'(out_valid), 64'd0);

      // Load-use interlock for three cycles, then release.
      applyStimulus(hz, 64'h2000, 1'b0);
      #1;
      checkOutput("hz_hazard", 64'(hazard), 64'd1);
      checkOutput("hz_in_ready", 64'(in_ready), 64'd0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         checkOutput($sformatf("hz_stall_cnt%0d", k), 64'(stall_cnt), 64'(k));
         checkOutput($sformatf("hz_out_valid%0d", k), 64'(out_valid), 64'd0);
      end
      hz.fp = 3'b000;
      applyStimulus(hz, 64'h2000, 1'b1);
      #1;
      checkOutput("hz_release_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      tick();
      checkOutput("hz_drain", 64'(out_valid), 64'd0);

      // Hold under backpressure with a new instruction waiting.
      out_ready = 1'b0;
      applyStimulus(vecs[3], 64'h3000, 1'b1);
      tick();
      applyStimulus(vecs[0], 64'h3004, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
         checkOutput($sformatf("hold%0d_out_valid", k), 64'(out_valid), 64'd1);
         checkOutput($sformatf("hold%0d_pc", k), out_pc, 64'h3000);
         checkOutput($sformatf("hold%0d_srca", k), out_srca, 64'hB1);
         tick();
      end
      out_ready = 1'b1;
      applyStimulus(vecs[0], 64'h3004, 1'b1);
      #1;
      checkOutput("hold_release_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      tick();
      checkOutput("hold_drain", 64'(out_valid), 64'd0);

      // Flush kills the held instruction and the incoming one.
      out_ready = 1'b0;
      applyStimulus(vecs[1], 64'h4000, 1'b1);
      tick();
      applyStimulus(vecs[2], 64'h4004, 1'b0);
      flush = 1'b1;
      #1;
      checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
      tick();
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      void'(sb.pop_front());
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      checkOutput("flush_not_issued", 64'(out_valid), 64'd0);

      // Counter is already at its ceiling; five more stall cycles must not wrap.
      hz.fp = 3'b001;
      applyStimulus(hz, 64'h5000, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput($sformatf("sat%0d_stall_cnt", k), 64'(stall_cnt), 64'd3);
      end

      // Reset during an otherwise-accepted capture.
      applyStimulus(vecs[5], 64'h6000, 1'b0);
      reset = 1'b1;
      tick();
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
      checkOutput("midrst_out_pc", out_pc, 64'd0);
      checkOutput("midrst_out_srca", out_srca, 64'd0);
      reset = 1'b0;
      applyStimulus(hz, 64'h7000, 1'b0);
      tick();
      checkOutput("postrst_stall_cnt", 64'(stall_cnt), 64'd1);
      checkOutput("postrst_out_valid", 64'(out_valid), 64'd0);
      in_valid = 1'b0;
      tick();

      checkOutput("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
